// File: rtl/swap_datapath_pkg.sv
// Shared definitions for the swap datapath: default widths, bus-select codes
// and small helpers for the bus priority decode and driver counting.
package swap_datapath_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef logic [2:0] bus_sel_t;

  localparam bus_sel_t SEL_NONE = 3'd0;
  localparam bus_sel_t SEL_EXT  = 3'd1;
  localparam bus_sel_t SEL_R1   = 3'd2;
  localparam bus_sel_t SEL_R2   = 3'd3;
  localparam bus_sel_t SEL_R3   = 3'd4;

  // Fixed priority: Extern, then R1, R2, R3.
  function automatic bus_sel_t bus_sel(input logic ext, input logic r1_out,
                                       input logic r2_out, input logic r3_out);
    if (ext) begin
      return SEL_EXT;
    end else if (r1_out) begin
      return SEL_R1;
    end else if (r2_out) begin
      return SEL_R2;
    end else if (r3_out) begin
      return SEL_R3;
    end
    return SEL_NONE;
  endfunction

  function automatic logic [2:0] drv_count(input logic ext, input logic r1_out,
                                           input logic r2_out, input logic r3_out);
    return {2'b00, ext} + {2'b00, r1_out} + {2'b00, r2_out} + {2'b00, r3_out};
  endfunction

endpackage

// File: rtl/swap_datapath_if.sv
// Bundle between the swap controller (master) and the datapath (slave).
// master drives: data, ext, r1_in..r3_in, r1_out..r3_out, done
// slave drives:  bus_wires, r1_q..r3_q, bus_err, swap_count, done_q
interface swap_datapath_if #(
  parameter int unsigned N       = swap_datapath_pkg::DATA_W,
  parameter int unsigned COUNT_W = swap_datapath_pkg::CNT_W
);

  logic [N-1:0]       data;
  logic               ext;
  logic               r1_in;
  logic               r2_in;
  logic               r3_in;
  logic               r1_out;
  logic               r2_out;
  logic               r3_out;
  logic               done;

  logic [N-1:0]       bus_wires;
  logic [N-1:0]       r1_q;
  logic [N-1:0]       r2_q;
  logic [N-1:0]       r3_q;
  logic               bus_err;
  logic [COUNT_W-1:0] swap_count;
  logic               done_q;

  modport master (
    output data, ext, r1_in, r2_in, r3_in, r1_out, r2_out, r3_out, done,
    input  bus_wires, r1_q, r2_q, r3_q, bus_err, swap_count, done_q
  );

  modport slave (
    input  data, ext, r1_in, r2_in, r3_in, r1_out, r2_out, r3_out, done,
    output bus_wires, r1_q, r2_q, r3_q, bus_err, swap_count, done_q
  );

endinterface

// File: rtl/swap_datapath_regn_en.sv
// N-bit register with load enable and asynchronous active-high reset.
// Ports: i_clk, i_rst, i_en (load), i_d (next value), o_q (contents).
module regn_en #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/swap_datapath.sv
// Datapath stage for the three-register swap controller: shared N-bit bus with
// fixed-priority mux, three loadable registers, sticky bus-conflict flag,
// completed-swap counter and a one-clock-delayed done pulse.
// Ports: i_clk, i_rst (async, active-high), io_bus (slave side of swap_datapath_if).
module swap_datapath import swap_datapath_pkg::*; #(
  parameter int unsigned N       = DATA_W,
  parameter int unsigned COUNT_W = CNT_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  swap_datapath_if.slave  io_bus
);

  bus_sel_t     w_sel;
  logic [N-1:0] w_bus;
  logic [N-1:0] w_r1_q;
  logic [N-1:0] w_r2_q;
  logic [N-1:0] w_r3_q;
  logic [2:0]   w_drv_cnt;
  logic         w_conflict;

  logic               r_bus_err;
  logic [COUNT_W-1:0] r_swap_count;
  logic               r_done_q;

  assign w_sel = bus_sel(io_bus.ext, io_bus.r1_out, io_bus.r2_out, io_bus.r3_out);

  always_comb begin
    w_bus = '0;
    case (w_sel)
      SEL_EXT: w_bus = io_bus.data;
      SEL_R1:  w_bus = w_r1_q;
      SEL_R2:  w_bus = w_r2_q;
      SEL_R3:  w_bus = w_r3_q;
      default: w_bus = '0;
    endcase
  end

  // A register that drives and loads in the same cycle re-captures its own value.
  regn_en #(.N(N)) u_r1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (io_bus.r1_in),
    .i_d   (w_bus),
    .o_q   (w_r1_q)
  );

  regn_en #(.N(N)) u_r2 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (io_bus.r2_in),
    .i_d   (w_bus),
    .o_q   (w_r2_q)
  );

  regn_en #(.N(N)) u_r3 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (io_bus.r3_in),
    .i_d   (w_bus),
    .o_q   (w_r3_q)
  );

  assign w_drv_cnt  = drv_count(io_bus.ext, io_bus.r1_out, io_bus.r2_out, io_bus.r3_out);
  assign w_conflict = (w_drv_cnt > 3'd1);

  // Counting is deliberately not gated by the conflict flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bus_err    <= 1'b0;
      r_swap_count <= '0;
      r_done_q     <= 1'b0;
    end else begin
      if (w_conflict) begin
        r_bus_err <= 1'b1;
      end
      if (io_bus.done) begin
        r_swap_count <= r_swap_count + COUNT_W'(1);
      end
      r_done_q <= io_bus.done;
    end
  end

  assign io_bus.bus_wires  = w_bus;
  assign io_bus.r1_q       = w_r1_q;
  assign io_bus.r2_q       = w_r2_q;
  assign io_bus.r3_q       = w_r3_q;
  assign io_bus.bus_err    = r_bus_err;
  assign io_bus.swap_count = r_swap_count;
  assign io_bus.done_q     = r_done_q;

endmodule

// File: tb/tb_swap_datapath.sv
module tb_swap_datapath;
  import swap_datapath_pkg::*;

  localparam int unsigned N  = DATA_W;
  localparam int unsigned CW = CNT_W;

  typedef struct {
    logic         ext;
    logic [N-1:0] data;
    logic         r1i, r2i, r3i;
    logic         r1o, r2o, r3o;
    logic         done;
  } ctl_t;

  typedef struct {
    ctl_t          c;
    logic [N-1:0]  e_bus, e_r1, e_r2, e_r3;
    logic          e_err;
    logic [CW-1:0] e_cnt;
    logic          e_dq;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swap_datapath_if #(.N(N), .COUNT_W(CW)) dif ();

  swap_datapath #(.N(N), .COUNT_W(CW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (dif)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [N-1:0]  m_r [3];
  logic          m_err;
  logic [CW-1:0] m_cnt;
  logic          m_dq;
  logic [N-1:0]  bus_pre;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t mk(input logic e, input logic [N-1:0] d, input logic r1i,
                              input logic r2i, input logic r3i, input logic r1o,
                              input logic r2o, input logic r3o, input logic dn);
    ctl_t c;
    c.ext = e; c.data = d;
    c.r1i = r1i; c.r2i = r2i; c.r3i = r3i;
    c.r1o = r1o; c.r2o = r2o; c.r3o = r3o;
    c.done = dn;
    return c;
  endfunction

  function automatic logic [N-1:0] m_bus(input ctl_t c);
    bus_sel_t s;
    if (c.ext)      s = SEL_EXT;
    else if (c.r1o) s = SEL_R1;
    else if (c.r2o) s = SEL_R2;
    else if (c.r3o) s = SEL_R3;
    else            s = SEL_NONE;
    case (s)
      SEL_EXT: return c.data;
      SEL_R1:  return m_r[0];
      SEL_R2:  return m_r[1];
      SEL_R3:  return m_r[2];
      default: return '0;
    endcase
  endfunction

  task automatic m_clock(input ctl_t c);
    logic [N-1:0] b;
    int n;
    b = m_bus(c);
    n = int'(c.ext) + int'(c.r1o) + int'(c.r2o) + int'(c.r3o);
    if (c.r1i) m_r[0] = b;
    if (c.r2i) m_r[1] = b;
    if (c.r3i) m_r[2] = b;
    if (n > 1) m_err = 1'b1;
    if (c.done) m_cnt = CW'((int'(m_cnt) + 1) % (1 << CW));
    m_dq = c.done;
  endtask

  task automatic m_reset();
    m_r[0] = '0; m_r[1] = '0; m_r[2] = '0;
    m_err = 1'b0; m_cnt = '0; m_dq = 1'b0;
  endtask

  task automatic drive(input ctl_t c);
    dif.ext = c.ext; dif.data = c.data;
    dif.r1_in = c.r1i; dif.r2_in = c.r2i; dif.r3_in = c.r3i;
    dif.r1_out = c.r1o; dif.r2_out = c.r2o; dif.r3_out = c.r3o;
    dif.done = c.done;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input ctl_t c);
    drive(c);
    #1;
    bus_pre = dif.bus_wires;
    @(posedge clk);
    m_clock(c);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".r1"},  32'(dif.r1_q), 32'(m_r[0]));
    check({tag, ".r2"},  32'(dif.r2_q), 32'(m_r[1]));
    check({tag, ".r3"},  32'(dif.r3_q), 32'(m_r[2]));
    check({tag, ".err"}, 32'(dif.bus_err), 32'(m_err));
    check({tag, ".cnt"}, 32'(dif.swap_count), 32'(m_cnt));
    check({tag, ".dq"},  32'(dif.done_q), 32'(m_dq));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    drive(mk(0, '0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_state(tag);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ctl_t idle;
    ctl_t c;
    logic [N-1:0] e;
    idle = mk(0, '0, 0, 0, 0, 0, 0, 0, 0);

    // Init-and-swap table: load 5A/C3, then R3<-R2, R2<-R1, R1<-R3 with Done.
    vecs[0] = '{c: mk(1, 8'h5A, 1, 0, 0, 0, 0, 0, 0), e_bus: 8'h5A,
                e_r1: 8'h5A, e_r2: 8'h00, e_r3: 8'h00, e_err: 0, e_cnt: 8'd0, e_dq: 0};
    vecs[1] = '{c: mk(1, 8'hC3, 0, 1, 0, 0, 0, 0, 0), e_bus: 8'hC3,
                e_r1: 8'h5A, e_r2: 8'hC3, e_r3: 8'h00, e_err: 0, e_cnt: 8'd0, e_dq: 0};
    vecs[2] = '{c: mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0), e_bus: 8'hC3,
                e_r1: 8'h5A, e_r2: 8'hC3, e_r3: 8'hC3, e_err: 0, e_cnt: 8'd0, e_dq: 0};
    vecs[3] = '{c: mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 0), e_bus: 8'h5A,
                e_r1: 8'h5A, e_r2: 8'h5A, e_r3: 8'hC3, e_err: 0, e_cnt: 8'd0, e_dq: 0};
    vecs[4] = '{c: mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 1), e_bus: 8'hC3,
                e_r1: 8'hC3, e_r2: 8'h5A, e_r3: 8'hC3, e_err: 0, e_cnt: 8'd1, e_dq: 1};
    vecs[5] = '{c: mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0), e_bus: 8'h00,
                e_r1: 8'hC3, e_r2: 8'h5A, e_r3: 8'hC3, e_err: 0, e_cnt: 8'd1, e_dq: 0};

    drive(idle);
    @(negedge clk);
    m_reset();
    check_state("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].c);
      check($sformatf("vec%0d.bus", i), 32'(bus_pre), 32'(vecs[i].e_bus));
      check($sformatf("vec%0d.r1", i),  32'(dif.r1_q), 32'(vecs[i].e_r1));
      check($sformatf("vec%0d.r2", i),  32'(dif.r2_q), 32'(vecs[i].e_r2));
      check($sformatf("vec%0d.r3", i),  32'(dif.r3_q), 32'(vecs[i].e_r3));
      check($sformatf("vec%0d.err", i), 32'(dif.bus_err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d.cnt", i), 32'(dif.swap_count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.dq", i),  32'(dif.done_q), 32'(vecs[i].e_dq));
    end

    // Idle bus: registers hold for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(idle);
      check("idle.bus", 32'(bus_pre), 32'h0);
      check_state("idle");
    end

    // Conflict: R1 and R2 both drive; R1 wins, flag sticks until reset
    step(mk(1, 8'h11, 1, 0, 0, 0, 0, 0, 0));
    step(mk(1, 8'h22, 0, 1, 0, 0, 0, 0, 0));
    step(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
    check("conf.bus", 32'(bus_pre), 32'h11);
    check("conf.r3", 32'(dif.r3_q), 32'h11);
    check("conf.err", 32'(dif.bus_err), 32'h1);
    for (int i = 0; i < 20; i++) step(idle);
    check("conf.sticky", 32'(dif.bus_err), 32'h1);
    do_reset("conf.rst");

    // Extern versus register driver
    step(mk(1, 8'hF0, 1, 0, 0, 0, 0, 1, 0));
    check("extdrv.bus", 32'(bus_pre), 32'hF0);
    check("extdrv.r1", 32'(dif.r1_q), 32'hF0);
    check("extdrv.err", 32'(dif.bus_err), 32'h1);
    do_reset("extdrv.rst");

    // Counter wrap
    for (int i = 0; i < 255; i++) step(mk(0, '0, 0, 0, 0, 0, 0, 0, 1));
    check("wrap.ff", 32'(dif.swap_count), 32'hFF);
    step(mk(0, '0, 0, 0, 0, 0, 0, 0, 1));
    check("wrap.00", 32'(dif.swap_count), 32'h00);
    check_state("wrap");
    do_reset("wrap.rst");

    // Reset mid-swap, asserted between edges during the second step
    step(mk(1, 8'hAA, 1, 0, 0, 0, 0, 0, 0));
    step(mk(1, 8'h55, 0, 1, 0, 0, 0, 0, 0));
    step(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 1));
    check("mid.pre_r3", 32'(dif.r3_q), 32'h55);
    drive(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    check("mid.r1", 32'(dif.r1_q), 32'h0);
    check("mid.r2", 32'(dif.r2_q), 32'h0);
    check("mid.r3", 32'(dif.r3_q), 32'h0);
    check("mid.cnt", 32'(dif.swap_count), 32'h0);
    check("mid.dq", 32'(dif.done_q), 32'h0);
    check("mid.err", 32'(dif.bus_err), 32'h0);
    m_reset();
    drive(idle);
    #1;
    rst = 1'b0;
    @(negedge clk);
    step(mk(1, 8'h3C, 0, 1, 0, 0, 0, 0, 0));
    check("mid.resume_r2", 32'(dif.r2_q), 32'h3C);
    check_state("mid.resume");

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      c = mk(($urandom_range(3) == 0), N'($urandom), ($urandom_range(2) == 0),
             ($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(3) == 0),
             ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      e = m_bus(c);
      step(c);
      check("rnd.bus", 32'(bus_pre), 32'(e));
      check_state("rnd");
      if (i == 150) do_reset("rnd.rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
